// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared definitions for the IFU/LSU AXI-Lite arbiter.
//   state_e     : arbiter FSM states
//   RESP_*      : AXI response codes (passed through untouched by the arbiter)
//   OWNER_*     : encoding of the owner register (0 = IFU/m0, 1 = LSU/m1)
package ysyx_24100006_axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrResp
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24100006_arb_grant2.sv
// Combinational two-way grant.
//   req_i[1:0] : request from m1 (bit 1) and m0 (bit 0)
//   last_i     : owner of the most recently completed transaction
//   gnt_o[1:0] : one-hot grant, zero when nobody requests
// Build option ARB_RR_EN: when defined, a tie goes to !last_i (round-robin);
// otherwise m1 (LSU) always wins a tie and last_i is ignored.
module ysyx_24100006_arb_grant2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

`ifndef ARB_RR_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11: begin
`ifdef ARB_RR_EN
        gnt_o = last_i ? 2'b01 : 2'b10;
`else
        gnt_o = 2'b10;
`endif
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_axi_arbiter.sv
// 2-master -> 1-slave AXI-Lite arbiter. m0 (IFU) is read-only, m1 (LSU) reads and writes.
// One transaction is in flight at a time; the grant is held until the slave's R or B handshake.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-low reset
//   m0_ar*/m0_r*      : IFU read address / read data channels
//   m1_ar*/m1_r*      : LSU read address / read data channels
//   m1_aw*/m1_w*/m1_b*: LSU write address / write data / write response channels
//   s_*               : downstream slave port (this block is the master)
// Build option ARB_RR_EN selects round-robin tie breaking (see ysyx_24100006_arb_grant2);
// without it m1 wins every tie.
module ysyx_24100006_axi_arbiter
  import ysyx_24100006_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // m0 (IFU) read
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  // m1 (LSU) read
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  // m1 (LSU) write
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  // downstream slave
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic [1:0] req, gnt;
  logic       s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs;

  // m1 only counts as a write requester once both AW and W are offered.
  assign req = {m1_arvalid | (m1_awvalid & m1_wvalid), m0_arvalid};

  ysyx_24100006_arb_grant2 u_grant (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign s_ar_hs = s_arvalid & s_arready;
  assign s_r_hs  = s_rvalid  & s_rready;
  assign s_aw_hs = s_awvalid & s_awready;
  assign s_w_hs  = s_wvalid  & s_wready;
  assign s_b_hs  = s_bvalid  & s_bready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      owner_q   <= OWNER_IFU;
      last_q    <= OWNER_LSU;  // so the first round-robin tie goes to m0
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          owner_d   = gnt[1] ? OWNER_LSU : OWNER_IFU;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          // m1 offering both a read and a write is served read first.
          state_d   = (gnt[1] && !m1_arvalid) ? StWrAddr : StRdAddr;
        end
      end
      StRdAddr: begin
        if (s_ar_hs) state_d = StRdData;
      end
      StRdData: begin
        if (s_r_hs) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      StWrAddr: begin
        if (s_aw_hs) aw_done_d = 1'b1;
        if (s_w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | s_aw_hs) && (w_done_q | s_w_hs)) state_d = StWrResp;
      end
      StWrResp: begin
        if (s_b_hs) begin
          state_d = StIdle;
          last_d  = OWNER_LSU;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Channel muxes. Everything not owned in the current state stays at zero; reset forces all
  // outputs low combinationally so nothing leaks out while reset is held.
  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_bready   = 1'b0;
    if (reset) begin
      unique case (state_q)
        StRdAddr: begin
          if (owner_q == OWNER_LSU) begin
            s_arvalid  = m1_arvalid;
            s_araddr   = m1_araddr;
            m1_arready = s_arready;
          end else begin
            s_arvalid  = m0_arvalid;
            s_araddr   = m0_araddr;
            m0_arready = s_arready;
          end
        end
        StRdData: begin
          if (owner_q == OWNER_LSU) begin
            m1_rvalid = s_rvalid;
            m1_rdata  = s_rdata;
            m1_rresp  = s_rresp;
            s_rready  = m1_rready;
          end else begin
            m0_rvalid = s_rvalid;
            m0_rdata  = s_rdata;
            m0_rresp  = s_rresp;
            s_rready  = m0_rready;
          end
        end
        StWrAddr: begin
          // Each half is masked once accepted, so the slave sees exactly one AW and one W.
          s_awvalid  = m1_awvalid & ~aw_done_q;
          s_awaddr   = m1_awaddr;
          m1_awready = s_awready & ~aw_done_q;
          s_wvalid   = m1_wvalid & ~w_done_q;
          s_wdata    = m1_wdata;
          s_wstrb    = m1_wstrb;
          m1_wready  = s_wready & ~w_done_q;
        end
        StWrResp: begin
          m1_bvalid = s_bvalid;
          m1_bresp  = s_bresp;
          s_bready  = m1_bready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Self-checking bench for ysyx_24100006_axi_arbiter: directed reset checks, then randomized
// rounds of simultaneous requests served by a random-latency slave, checked against a
// transaction-order model of the arbitration rule.
module tb_ysyx_24100006_axi_arbiter;

`ifdef ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [1:0]  m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp;

  always #5 clk = ~clk;

  ysyx_24100006_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  // Every DUT-driven valid/ready, and every DUT-driven data/resp OR'd together.
  logic [11:0] ctl_out;
  logic [31:0] data_or;
  assign ctl_out = {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready,
                    m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
  assign data_or = m0_rdata | m1_rdata | s_araddr | s_awaddr | s_wdata | {28'b0, s_wstrb} |
                   {30'b0, m0_rresp | m1_rresp | m1_bresp};

  typedef struct {
    bit          wr;
    bit          own;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          mdl_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = 0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = 0; m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic recover();
    clear_inputs();
    reset = 0;
    step();
    reset = 1;
    mdl_last = 1'b1;
  endtask

  // One round: the chosen requesters all raise their requests in the same cycle with the arbiter
  // idle. The model lists the order in which the transactions must reach the slave.
  task automatic run_round(input bit do_m0, input bit do_m1r, input bit do_m1w);
    txn_t        exp_q[$];
    txn_t        t, f;
    bit          p0, p1r, p1w, r1, w, lst, fok;
    bit          ar, r, aw, wh, b, m0a, m1a, m1aw, m1w;
    bit          rd_pend, b_pend;
    int          rdly, bdly, aw_cnt, w_cnt, m_aw_cnt, m_w_cnt, cyc;
    logic [31:0] a0, a1r, a1w, wd, rd_data;
    logic [3:0]  ws;
    logic [1:0]  rd_resp, b_resp;

    a0  = {$urandom} & 32'hFFFF_FFFC;
    a1r = {$urandom} & 32'hFFFF_FFFC;
    a1w = {$urandom} & 32'hFFFF_FFFC;
    wd  = $urandom;
    ws  = 4'($urandom_range(1, 15));

    p0 = do_m0; p1r = do_m1r; p1w = do_m1w; lst = mdl_last;
    while (p0 || p1r || p1w) begin
      r1 = p1r || p1w;
      if (p0 && r1) w = RrEn ? ~lst : 1'b1;
      else          w = r1;
      t = '{wr: 1'b0, own: w, addr: a0, data: '0, strb: '0};
      if (!w)       p0 = 1'b0;
      else if (p1r) begin t.addr = a1r; p1r = 1'b0; end
      else begin t.wr = 1'b1; t.addr = a1w; t.data = wd; t.strb = ws; p1w = 1'b0; end
      exp_q.push_back(t);
      lst = w;
    end
    mdl_last = lst;

    m0_arvalid = do_m0;  m0_araddr = a0;
    m1_arvalid = do_m1r; m1_araddr = a1r;
    m1_awvalid = do_m1w; m1_awaddr = a1w;
    m1_wvalid  = do_m1w; m1_wdata  = wd; m1_wstrb = ws;
    rd_pend = 0; b_pend = 0; rdly = 0; bdly = 0; rd_data = 0; rd_resp = 0; b_resp = 0;
    aw_cnt = 0; w_cnt = 0; m_aw_cnt = 0; m_w_cnt = 0; cyc = 0;

    while (exp_q.size() != 0 && cyc < 400) begin
      cyc++;
      @(negedge clk);
      fok = exp_q.size() != 0;
      f = fok ? exp_q[0] : '{wr: 1'b0, own: 1'b0, addr: '0, data: '0, strb: '0};

      check_eq("m0_rvalid", 64'(m0_rvalid), 64'(s_rvalid && fok && !f.wr && !f.own));
      check_eq("m1_rvalid", 64'(m1_rvalid), 64'(s_rvalid && fok && !f.wr && f.own));
      check_eq("m1_bvalid", 64'(m1_bvalid), 64'(s_bvalid && fok && f.wr));
      if (rd_pend) check_eq("s_rready", 64'(s_rready), 64'(f.own ? m1_rready : m0_rready));
      if (b_pend)  check_eq("s_bready", 64'(s_bready), 64'(m1_bready));
      if (m0_arready) check_eq("m0_arready_owner", 64'({fok, f.wr, f.own}), 64'(3'b100));
      if (m1_arready) check_eq("m1_arready_owner", 64'({fok, f.wr, f.own}), 64'(3'b101));
      if (m1_awready) check_eq("m1_awready_owner", 64'({fok, f.wr}), 64'(2'b11));
      if (m1_wready)  check_eq("m1_wready_owner", 64'({fok, f.wr}), 64'(2'b11));

      ar   = s_arvalid & s_arready;
      r    = s_rvalid & s_rready;
      aw   = s_awvalid & s_awready;
      wh   = s_wvalid & s_wready;
      b    = s_bvalid & s_bready;
      m0a  = m0_arvalid & m0_arready;
      m1a  = m1_arvalid & m1_arready;
      m1aw = m1_awvalid & m1_awready;
      m1w  = m1_wvalid & m1_wready;

      if (ar) begin
        check_eq("ar_order", {31'b0, 1'b0, s_araddr}, {31'b0, f.wr | !fok, f.addr});
        check_eq("ar_fwd", 64'(f.own ? m1a : m0a), 64'd1);
        rd_pend = 1; rdly = $urandom_range(0, 3);
        rd_data = $urandom; rd_resp = 2'($urandom_range(0, 3));
      end
      if (r) begin
        check_eq("rdata", 64'(f.own ? m1_rdata : m0_rdata), 64'(rd_data));
        check_eq("rresp", 64'(f.own ? m1_rresp : m0_rresp), 64'(rd_resp));
        if (fok) void'(exp_q.pop_front());
        rd_pend = 0;
      end
      if (b) begin
        check_eq("bresp", 64'(m1_bresp), 64'(b_resp));
        if (fok) void'(exp_q.pop_front());
        b_pend = 0; aw_cnt = 0; w_cnt = 0;
      end
      if (aw) begin
        check_eq("aw_addr", {31'b0, 1'b1, s_awaddr}, {31'b0, f.wr & fok, f.addr});
        check_eq("s_aw_once", 64'(aw_cnt), 64'd0);
        aw_cnt++;
      end
      if (wh) begin
        check_eq("w_data", {27'b0, 1'b1, s_wstrb, s_wdata}, {27'b0, f.wr & fok, f.strb, f.data});
        check_eq("s_w_once", 64'(w_cnt), 64'd0);
        w_cnt++;
      end
      if (aw_cnt != 0 && w_cnt != 0 && !b_pend) begin
        b_pend = 1; bdly = $urandom_range(0, 3); b_resp = 2'($urandom_range(0, 3));
      end
      if (m1aw) begin check_eq("m1_aw_once", 64'(m_aw_cnt), 64'd0); m_aw_cnt++; end
      if (m1w)  begin check_eq("m1_w_once", 64'(m_w_cnt), 64'd0);   m_w_cnt++;  end

      step();
      if (m0a) m0_arvalid = 0;
      if (m1a) m1_arvalid = 0;
      // Write valids are deliberately held until both halves are accepted on the m1 side.
      if (m_aw_cnt != 0 && m_w_cnt != 0) begin
        m1_awvalid = 0; m1_wvalid = 0; m_aw_cnt = 0; m_w_cnt = 0;
      end
      m0_rready = ($urandom_range(0, 3) != 0);
      m1_rready = ($urandom_range(0, 3) != 0);
      m1_bready = ($urandom_range(0, 3) != 0);
      s_arready = ($urandom_range(0, 2) != 0);
      s_awready = ($urandom_range(0, 2) != 0);
      s_wready  = ($urandom_range(0, 2) != 0);
      if (r) begin
        s_rvalid = 0; s_rdata = 0; s_rresp = 0;
      end else if (rd_pend) begin
        if (rdly > 0) rdly--;
        else begin s_rvalid = 1; s_rdata = rd_data; s_rresp = rd_resp; end
      end
      if (b) begin
        s_bvalid = 0; s_bresp = 0;
      end else if (b_pend) begin
        if (bdly > 0) bdly--;
        else begin s_bvalid = 1; s_bresp = b_resp; end
      end
    end

    if (exp_q.size() != 0) begin
      check_eq("round_timeout", 64'(exp_q.size()), 64'd0);
      recover();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    bit got_hs;
    int pat;

    // Reset held with every input asserted: nothing may come out.
    reset = 0;
    clear_inputs();
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_rready = 1;
    m1_arvalid = 1; m1_araddr = 32'h1234_5678; m1_rready = 1;
    m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h0200_0000; m1_wdata = 32'h1;
    m1_wstrb = 4'hF; m1_bready = 1;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b11;
    mdl_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_quiet", {20'b0, ctl_out, data_or}, 64'd0);
    end

    // Release with only m0 requesting: one idle arbitration cycle, then m0's address.
    step();
    clear_inputs();
    m0_arvalid = 1; m0_araddr = 32'h8000_0000;
    reset = 1;
    @(negedge clk);
    check_eq("arb_latency", 64'(s_arvalid), 64'd0);
    @(negedge clk);
    check_eq("first_grant", {31'b0, s_arvalid, s_araddr}, {31'b0, 1'b1, 32'h8000_0000});
    check_eq("first_grant_m1_quiet", 64'({m1_arready, m1_rvalid}), 64'd0);

    // Reset in the address phase: outputs drop at once, no grant survives.
    step();
    reset = 0; s_arready = 1;
    @(negedge clk);
    check_eq("rst_in_rdaddr", 64'(ctl_out), 64'd0);
    step();
    m0_arvalid = 0; s_arready = 0; reset = 1;
    repeat (2) begin
      @(negedge clk);
      check_eq("no_stale_grant", 64'(ctl_out), 64'd0);
    end

    // Reset while read data is pending from the slave.
    step();
    m0_arvalid = 1; m0_araddr = 32'h0200_0008; s_arready = 1; m0_rready = 0;
    got_hs = 0;
    for (int i = 0; i < 8 && !got_hs; i++) begin
      @(negedge clk);
      got_hs = s_arvalid & s_arready;
      step();
    end
    check_eq("mid_ar_hs", 64'(got_hs), 64'd1);
    m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b01;
    @(negedge clk);
    check_eq("rdata_fwd", {29'b0, m0_rvalid, m0_rdata, m0_rresp}, {29'b0, 1'b1, 32'hDEAD_BEEF, 2'b01});
    check_eq("rdata_m1_quiet", 64'(m1_rvalid), 64'd0);
    step();
    reset = 0; m0_rready = 1;
    @(negedge clk);
    check_eq("rst_in_rddata", {20'b0, ctl_out, data_or}, 64'd0);
    step();
    reset = 1; clear_inputs();
    mdl_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("post_rst_idle", 64'(ctl_out), 64'd0);
    end
    step();

    // Repeated ties between m0 and m1 reads, then a lone write and a lone read.
    repeat (4) run_round(1'b1, 1'b1, 1'b0);
    run_round(1'b0, 1'b0, 1'b1);
    run_round(1'b1, 1'b0, 1'b0);

    // Random mixes of requesters.
    for (int k = 0; k < 60; k++) begin
      pat = $urandom_range(1, 7);
      run_round(pat[0], pat[1], pat[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
